// File: rtl/shm_page_alloc.sv
// Free-page allocator owning the page link table and free list; page 0 is NIL.
// Latency: fail 1 cycle, ALLOC k / FREE L respond after k / L edges; lookup is 1 cycle.
// Backpressure: req_ready low while walking a chain; the response has none.
module shm_page_alloc #(
    parameter int PAGE_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [PAGE_BITS-1:0] req_count,
    input  logic [PAGE_BITS-1:0] req_ptr,
    output logic                 rsp_valid,
    output logic                 rsp_ok,
    output logic [PAGE_BITS-1:0] rsp_ptr,
    input  logic [PAGE_BITS-1:0] lk_addr,
    output logic [PAGE_BITS-1:0] lk_next,
    output logic [PAGE_BITS-1:0] free_count
);
    localparam int N = 1 << PAGE_BITS;
    localparam logic [PAGE_BITS-1:0] ONE     = PAGE_BITS'(1);
    localparam logic [PAGE_BITS-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_FREE} state_t;

    state_t               state, state_nxt;
    logic [PAGE_BITS-1:0] link [N];
    logic [PAGE_BITS-1:0] free_head;
    logic [PAGE_BITS-1:0] head;
    logic [PAGE_BITS-1:0] cur;
    logic [PAGE_BITS-1:0] remaining;
    logic [PAGE_BITS-1:0] len;
    logic [PAGE_BITS-1:0] op_count;
    logic [PAGE_BITS-1:0] cur_link;
    logic                 accept;
    logic                 alloc_fail;
    logic                 free_fail;

    assign cur_link   = link[cur];
    assign accept     = req_valid && req_ready;
    assign alloc_fail = (req_count == '0) || (req_count > free_count);
    assign free_fail  = (req_ptr == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && !req_op && !alloc_fail) state_nxt = S_ALLOC;
                if (accept &&  req_op && !free_fail)  state_nxt = S_FREE;
            end
            S_ALLOC: if (remaining == '0) state_nxt = S_IDLE;
            S_FREE:  if (cur_link == '0 || len == LEN_MAX) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
    end

    // Table reads use pre-edge values, so a same-cycle write and lookup return old data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                link[i] <= (i >= 1 && i <= N - 2) ? PAGE_BITS'(i + 1) : '0;
            free_head  <= ONE;
            free_count <= LEN_MAX;
            head       <= '0;
            cur        <= '0;
            remaining  <= '0;
            len        <= '0;
            op_count   <= '0;
            rsp_valid  <= 1'b0;
            rsp_ok     <= 1'b0;
            rsp_ptr    <= '0;
            lk_next    <= '0;
        end else begin
            lk_next   <= link[lk_addr];
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
            rsp_ptr   <= '0;
            case (state)
                S_IDLE: begin
                    if (accept && !req_op) begin
                        if (alloc_fail) begin
                            rsp_valid <= 1'b1;
                        end else begin
                            head      <= free_head;
                            cur       <= free_head;
                            remaining <= req_count - ONE;
                            op_count  <= req_count;
                        end
                    end else if (accept && req_op) begin
                        if (free_fail) begin
                            rsp_valid <= 1'b1;
                        end else begin
                            head <= req_ptr;
                            cur  <= req_ptr;
                            len  <= ONE;
                        end
                    end
                end
                S_ALLOC: begin
                    if (remaining != '0) begin
                        cur       <= cur_link;
                        remaining <= remaining - ONE;
                    end else begin
                        free_head  <= cur_link;
                        link[cur]  <= '0;
                        free_count <= free_count - op_count;
                        rsp_valid  <= 1'b1;
                        rsp_ok     <= 1'b1;
                        rsp_ptr    <= head;
                    end
                end
                S_FREE: begin
                    if (cur_link == '0) begin
                        link[cur]  <= free_head;
                        free_head  <= head;
                        free_count <= free_count + len;
                        rsp_valid  <= 1'b1;
                        rsp_ok     <= 1'b1;
                        rsp_ptr    <= head;
                    end else if (len == LEN_MAX) begin
                        // Chain longer than the table can hold: cyclic or corrupt.
                        rsp_valid <= 1'b1;
                    end else begin
                        cur <= cur_link;
                        len <= len + ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shm_page_alloc.sv
// Directed bench for shm_page_alloc with a transaction-level free-list model and per-cycle compare.
module tb_shm_page_alloc;
    localparam int PB = 2;
    localparam int N  = 1 << PB;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_op = 1'b0;
    logic [PB-1:0] req_count = '0;
    logic [PB-1:0] req_ptr = '0;
    logic [PB-1:0] lk_addr = '0;
    logic          req_ready, rsp_valid, rsp_ok;
    logic [PB-1:0] rsp_ptr, lk_next, free_count;

    shm_page_alloc #(.PAGE_BITS(PB)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_count(req_count), .req_ptr(req_ptr),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_ptr(rsp_ptr),
        .lk_addr(lk_addr), .lk_next(lk_next), .free_count(free_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state as of the latest accepted request, and as visible on the outputs.
    logic [PB-1:0] m_link [N];
    logic [PB-1:0] m_head, m_count;
    logic [PB-1:0] vis_link [N];
    logic [PB-1:0] vis_count;
    logic [PB-1:0] exp_lk;
    int            p_acc = -1;
    int            p_rsp = -1;
    logic          p_ok = 1'b0;
    logic [PB-1:0] p_ptr = '0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            m_link[i] = (i >= 1 && i <= N - 2) ? PB'(i + 1) : '0;
        m_head  = 1;
        m_count = PB'(N - 1);
        p_acc   = -1;
        p_rsp   = -1;
    endtask

    task automatic model_op(input logic op, input logic [PB-1:0] cnt, input logic [PB-1:0] ptr,
                            output logic ok, output logic [PB-1:0] rp, output int lat);
        logic [PB-1:0] cur;
        ok = 1'b0; rp = '0; lat = 0;
        if (!op) begin
            if (cnt != 0 && cnt <= m_count) begin
                cur = m_head;
                for (int i = 1; i < int'(cnt); i++) cur = m_link[cur];
                rp         = m_head;
                m_head     = m_link[cur];
                m_link[cur] = '0;
                m_count    = m_count - cnt;
                ok         = 1'b1;
                lat        = int'(cnt);
            end
        end else if (ptr != 0) begin
            cur = ptr;
            for (int l = 1; l < N; l++) begin
                if (m_link[cur] == 0) begin
                    m_link[cur] = m_head;
                    m_head      = ptr;
                    m_count     = m_count + PB'(l);
                    ok  = 1'b1;
                    rp  = ptr;
                    lat = l;
                    break;
                end else if (l == N - 1) begin
                    lat = l;
                    break;
                end
                cur = m_link[cur];
            end
        end
    endtask

    // Per-cycle compare: outputs sampled on the falling edge.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            exp_lk = reset_n ? vis_link[lk_addr] : '0;
            @(negedge clock);
            if (!reset_n) begin
                for (int i = 0; i < N; i++)
                    vis_link[i] = (i >= 1 && i <= N - 2) ? PB'(i + 1) : '0;
                vis_count = PB'(N - 1);
                exp_lk    = '0;
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_req_ready", req_ready, 1);
                check("rst_free_count", free_count, N - 1);
                check("rst_lk_next", lk_next, 0);
            end else begin
                if (cyc == p_rsp) begin
                    vis_link  = m_link;
                    vis_count = m_count;
                end
                check("rsp_valid", rsp_valid, int'(cyc == p_rsp));
                if (cyc == p_rsp) begin
                    check("rsp_ok", rsp_ok, p_ok);
                    check("rsp_ptr", rsp_ptr, p_ptr);
                end
                check("req_ready", req_ready, int'(!(cyc >= p_acc && cyc < p_rsp)));
                check("free_count", free_count, vis_count);
                check("lk_next", lk_next, exp_lk);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic do_req(input logic op, input logic [PB-1:0] cnt, input logic [PB-1:0] ptr);
        logic ok;
        logic [PB-1:0] rp;
        int lat;
        req_valid = 1'b1; req_op = op; req_count = cnt; req_ptr = ptr;
        @(posedge clock); #1;
        req_valid = 1'b0;
        model_op(op, cnt, ptr, ok, rp, lat);
        p_ok = ok; p_ptr = rp; p_acc = cyc; p_rsp = cyc + lat;
        repeat (lat) @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [PB-1:0] addr, input int exp, input string name);
        lk_addr = addr;
        @(posedge clock); #1;
        check(name, lk_next, exp);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_rsp(input string name, input int ok, input int ptr, input int c0, input int edges);
        check({name, "_valid"}, rsp_valid, 1);
        check({name, "_ok"}, rsp_ok, ok);
        check({name, "_ptr"}, rsp_ptr, ptr);
        check({name, "_lat"}, cyc - c0, edges);
    endtask

    int c0;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Reset contents.
        check("s1_free_count", free_count, 3);
        check("s1_ready", req_ready, 1);
        check("s1_rsp_valid", rsp_valid, 0);
        lookup(1, 2, "s1_lk1");
        lookup(2, 3, "s1_lk2");
        lookup(3, 0, "s1_lk3");

        // ALLOC 2 then ALLOC 1 back to back.
        c0 = cyc; do_req(1'b0, 2, 0); check_rsp("s2_alloc2", 1, 1, c0, 3);
        c0 = cyc; do_req(1'b0, 1, 0); check_rsp("s2_alloc1", 1, 3, c0, 2);
        check("s2_free_count", free_count, 0);
        lookup(1, 2, "s2_lk1");
        lookup(2, 0, "s2_lk2");

        // Immediate fails with an empty free list.
        c0 = cyc; do_req(1'b0, 1, 0); check_rsp("s3_alloc_empty", 0, 0, c0, 1);
        c0 = cyc; do_req(1'b0, 0, 0); check_rsp("s3_alloc_zero", 0, 0, c0, 1);
        c0 = cyc; do_req(1'b1, 0, 0); check_rsp("s3_free_nil", 0, 0, c0, 1);
        check("s3_free_count", free_count, 0);

        // FREE page 3, then the 1->2 chain onto it.
        c0 = cyc; do_req(1'b1, 0, 3); check_rsp("s4_free3", 1, 3, c0, 2);
        c0 = cyc; do_req(1'b1, 0, 1); check_rsp("s4_free1", 1, 1, c0, 3);
        check("s4_free_count", free_count, 3);
        lookup(2, 3, "s4_lk2");
        lookup(3, 0, "s4_lk3");
        c0 = cyc; do_req(1'b0, 2, 0); check_rsp("s4_alloc2", 1, 1, c0, 3);
        check("s4_free_count2", free_count, 1);

        // Cyclic chain 1->2->3->1 must be rejected after the length bound.
        apply_reset();
        @(posedge clock); #1;
        c0 = cyc; do_req(1'b0, 3, 0); check_rsp("s5_alloc3", 1, 1, c0, 4);
        dut.link[3] = 2'd1;
        m_link[3]   = 2'd1;
        vis_link[3] = 2'd1;
        c0 = cyc; do_req(1'b1, 0, 1); check_rsp("s5_free_cyclic", 0, 0, c0, 4);
        check("s5_free_count", free_count, 0);

        // Reset in the middle of a 3-page ALLOC.
        apply_reset();
        @(posedge clock); #1;
        begin
            logic ok;
            logic [PB-1:0] rp;
            int lat;
            req_valid = 1'b1; req_op = 1'b0; req_count = 3;
            @(posedge clock); #1;
            req_valid = 1'b0;
            model_op(1'b0, 3, 0, ok, rp, lat);
            p_ok = ok; p_ptr = rp; p_acc = cyc; p_rsp = cyc + lat;
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        model_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("s6_no_rsp", rsp_valid, 0);
        end
        check("s6_ready", req_ready, 1);
        check("s6_free_count", free_count, 3);
        lookup(1, 2, "s6_lk1");
        lookup(2, 3, "s6_lk2");
        lookup(3, 0, "s6_lk3");
        c0 = cyc; do_req(1'b0, 3, 0); check_rsp("s6_alloc3", 1, 1, c0, 4);

        repeat (2) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "timeout");
    end
endmodule
